// File: rtl/shift_unit_pipe_pkg.sv
// Token types shared by the shift pipeline and its neighbours.
//   FTk_t : forward token  {v valid, a, c condition, r, d data}
//   BTk_t : backward token {n not-ready, t, v, c}
package shift_unit_pipe_pkg;

    localparam int unsigned WIDTH_TK_DATA = 32;

    typedef struct packed {
        logic                     v;
        logic                     a;
        logic                     c;
        logic                     r;
        logic [WIDTH_TK_DATA-1:0] d;
    } FTk_t;

    typedef struct packed {
        logic n;
        logic t;
        logic v;
        logic c;
    } BTk_t;

endpackage

// File: rtl/shift_unit_pipe.sv
// Pipelined barrel shifter / rotator with condition-LUT flag output.
// Ports:
//   clock, reset          : single clock, synchronous active-high reset
//   I_En                  : execute enable
//   I_Opcode              : [2:0] mode, [3] OutCondB, [4] OutCondF
//   I_Cond                : condition LUT indexed by {Ovf, Lost, Result==0}
//   I_OperandA/I_OperandB : data token / shift-amount token
//   O_Result              : result token taken from the last stage
//   I_BTk / O_BTk         : downstream / upstream backward tokens
//   O_Busy                : any stage holds a token
module shift_unit_pipe
    import shift_unit_pipe_pkg::*;
#(
    parameter int unsigned WIDTH_DATA = shift_unit_pipe_pkg::WIDTH_TK_DATA,
    parameter int unsigned NUM_STAGES = 2,
    parameter int unsigned SAT_AMOUNT = 1,
    parameter int unsigned WIDTH_COND = 3
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     I_En,
    input  logic [4:0]               I_Opcode,
    input  logic [2**WIDTH_COND-1:0] I_Cond,
    input  FTk_t                     I_OperandA,
    input  FTk_t                     I_OperandB,
    output FTk_t                     O_Result,
    input  BTk_t                     I_BTk,
    output BTk_t                     O_BTk,
    output logic                     O_Busy
);

    localparam int unsigned AW   = $clog2(WIDTH_DATA);
    localparam int unsigned LAST = NUM_STAGES - 1;
    localparam int unsigned BASE = AW / NUM_STAGES;

    localparam logic [2:0] MODE_ASR = 3'b000;
    localparam logic [2:0] MODE_LSR = 3'b001;
    localparam logic [2:0] MODE_LSL = 3'b010;
    localparam logic [2:0] MODE_ROL = 3'b011;
    localparam logic [2:0] MODE_ROR = 3'b100;

    typedef struct packed {
        logic                  valid;
        logic                  a;
        logic                  c;
        logic                  r;
        logic [WIDTH_DATA-1:0] data;
        logic [AW-1:0]         amt;
        logic [2:0]            mode;
        logic                  condB;
        logic                  condF;
        logic                  ovf;
        logic                  lost;
    } stage_t;

    stage_t                st     [NUM_STAGES];
    stage_t                stIn   [NUM_STAGES];
    stage_t                stCalc [NUM_STAGES];
    logic [NUM_STAGES-1:0] adv;
    logic [NUM_STAGES-1:0] load;
    logic                  accept;
    logic                  btkN;
    logic                  lastZero;
    logic [WIDTH_COND-1:0] condIdx;
    logic                  cond;
    logic                  inOvf;
    logic                  unusedBits;

    // Amount bits are split LSB-first; the last stage takes the remainder.
    function automatic int unsigned stageLo(input int unsigned i);
        return i * BASE;
    endfunction

    function automatic int unsigned stageHi(input int unsigned i);
        return (i == LAST) ? AW : (i + 1) * BASE;
    endfunction

    // Apply the amount bits in [lo, hi) to a token, accumulating Lost.
    function automatic stage_t applyBits(input stage_t s, input int unsigned lo,
                                         input int unsigned hi);
        stage_t      r;
        int unsigned sh;
        r = s;
        for (int unsigned k = 0; k < AW; k++) begin
            if (k >= lo && k < hi && r.amt[k]) begin
                sh = 32'd1 << k;
                case (r.mode)
                    MODE_ASR: begin
                        r.lost = r.lost | (|(r.data << (WIDTH_DATA - sh)));
                        r.data = $signed(r.data) >>> sh;
                    end
                    MODE_LSR: begin
                        r.lost = r.lost | (|(r.data << (WIDTH_DATA - sh)));
                        r.data = r.data >> sh;
                    end
                    MODE_LSL: begin
                        r.lost = r.lost | (|(r.data >> (WIDTH_DATA - sh)));
                        r.data = r.data << sh;
                    end
                    MODE_ROL: r.data = (r.data << sh) | (r.data >> (WIDTH_DATA - sh));
                    MODE_ROR: r.data = (r.data >> sh) | (r.data << (WIDTH_DATA - sh));
                    default: ;
                endcase
            end
        end
        return r;
    endfunction

    // Handshake: advance propagates from the last stage backwards.
    always_comb begin
        adv       = '0;
        load      = '0;
        adv[LAST] = st[LAST].valid & ~I_BTk.n;
        for (int i = int'(LAST) - 1; i >= 0; i--) begin
            adv[i] = st[i].valid & (~st[i+1].valid | adv[i+1]);
        end
        btkN    = st[0].valid & ~adv[0];
        accept  = I_OperandA.v & I_OperandB.v & I_En & ~btkN;
        load[0] = accept;
        for (int unsigned i = 1; i < NUM_STAGES; i++) begin
            load[i] = adv[i-1];
        end
    end

    // Datapath: capture operands (with saturation) and run each stage's bit group.
    always_comb begin
        stIn[0]       = '0;
        inOvf         = |I_OperandB.d[WIDTH_DATA-1:AW];
        stIn[0].valid = 1'b1;
        stIn[0].a     = I_OperandA.a;
        stIn[0].c     = I_OperandA.c;
        stIn[0].r     = I_OperandA.r;
        stIn[0].data  = I_OperandA.d;
        stIn[0].amt   = I_OperandB.d[AW-1:0];
        stIn[0].mode  = I_Opcode[2:0];
        stIn[0].condB = I_Opcode[3];
        stIn[0].condF = I_Opcode[4];
        stIn[0].ovf   = inOvf;
        stIn[0].lost  = 1'b0;
        // Saturated shifts push every bit out; rotates keep the modulo amount.
        if (SAT_AMOUNT != 0 && inOvf &&
            (I_Opcode[2:0] inside {MODE_ASR, MODE_LSR, MODE_LSL})) begin
            stIn[0].data = (I_Opcode[2:0] == MODE_ASR) ?
                           {WIDTH_DATA{I_OperandA.d[WIDTH_DATA-1]}} : '0;
            stIn[0].lost = |I_OperandA.d;
            stIn[0].amt  = '0;
        end
        for (int unsigned i = 1; i < NUM_STAGES; i++) begin
            stIn[i] = st[i-1];
        end
        for (int unsigned i = 0; i < NUM_STAGES; i++) begin
            stCalc[i] = applyBits(stIn[i], stageLo(i), stageHi(i));
        end
    end

    // Stage registers: load, drain or hold; reset clears valid bits only.
    always_ff @(posedge clock) begin
        for (int unsigned i = 0; i < NUM_STAGES; i++) begin
            if (load[i]) begin
                st[i] <= stCalc[i];
            end else if (adv[i]) begin
                st[i].valid <= 1'b0;
            end
            if (reset) begin
                st[i].valid <= 1'b0;
            end
        end
    end

    // Output tokens and condition lookup from the last stage.
    always_comb begin
        lastZero   = (st[LAST].data == '0);
        condIdx    = WIDTH_COND'({st[LAST].ovf, st[LAST].lost, lastZero});
        cond       = I_Cond[condIdx];
        O_Result   = '0;
        O_Result.v = st[LAST].valid;
        O_Result.a = st[LAST].a;
        O_Result.r = st[LAST].r;
        O_Result.d = st[LAST].data;
        O_Result.c = st[LAST].condF ? cond : st[LAST].c;
        O_BTk      = '0;
        O_BTk.n    = btkN;
        O_BTk.t    = I_BTk.t;
        O_BTk.v    = I_BTk.v;
        O_BTk.c    = I_BTk.c;
        if (st[LAST].valid && st[LAST].condB) begin
            O_BTk.v = st[LAST].c;
            O_BTk.c = cond;
        end
        O_Busy = 1'b0;
        for (int unsigned i = 0; i < NUM_STAGES; i++) begin
            O_Busy = O_Busy | st[i].valid;
        end
    end

    assign unusedBits = ^{I_OperandB.a, I_OperandB.c, I_OperandB.r,
                          st[LAST].amt, st[LAST].mode};

endmodule

// File: tb/tb_shift_unit_pipe.sv
// Directed self-checking bench for shift_unit_pipe (W=32, N=2, saturating).
module tb_shift_unit_pipe;
    import shift_unit_pipe_pkg::*;

    logic       clock = 1'b0;
    logic       reset;
    logic       en;
    logic [4:0] opcode;
    logic [7:0] condLut;
    FTk_t       opA;
    FTk_t       opB;
    FTk_t       result;
    BTk_t       btkIn;
    BTk_t       btkOut;
    logic       busy;

    int checks = 0;
    int errors = 0;

    shift_unit_pipe #(
        .WIDTH_DATA(32),
        .NUM_STAGES(2),
        .SAT_AMOUNT(1),
        .WIDTH_COND(3)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .I_En      (en),
        .I_Opcode  (opcode),
        .I_Cond    (condLut),
        .I_OperandA(opA),
        .I_OperandB(opB),
        .O_Result  (result),
        .I_BTk     (btkIn),
        .O_BTk     (btkOut),
        .O_Busy    (busy)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [2:0] mode, input logic condB, input logic condF,
                         input logic aC, input logic [31:0] a, input logic [31:0] b);
        opA.v = 1'b1; opA.a = 1'b0; opA.c = aC; opA.r = 1'b0; opA.d = a;
        opB.v = 1'b1; opB.a = 1'b0; opB.c = 1'b0; opB.r = 1'b0; opB.d = b;
        opcode = {condF, condB, mode};
        en = 1'b1;
    endtask

    task automatic idle();
        opA.v = 1'b0;
        opB.v = 1'b0;
        en    = 1'b0;
    endtask

    // One token through the empty pipeline; leaves it sitting in the last stage.
    task automatic runOne(input string tag, input logic [2:0] mode, input logic condB,
                          input logic condF, input logic aC, input logic [31:0] a,
                          input logic [31:0] b, input logic [7:0] lut,
                          input logic [31:0] expD, input logic expC);
        condLut = lut;
        drive(mode, condB, condF, aC, a, b);
        tick();
        idle();
        check({tag, " v@1"}, 32'(result.v), 32'd0);
        tick();
        check({tag, " v@2"}, 32'(result.v), 32'd1);
        check({tag, " d"}, result.d, expD);
        check({tag, " c"}, 32'(result.c), 32'(expC));
    endtask

    logic [31:0] streamExp [6] = '{32'd1, 32'd4, 32'd12, 32'd32, 32'd80, 32'd192};
    int          sent;
    int          recv;
    logic        willAccept;
    logic        willDrain;
    logic        sawBackpressure;

    initial begin
        reset = 1'b1;
        en = 1'b0; opcode = '0; condLut = '0;
        opA = '0; opB = '0; btkIn = '0;
        tick();
        tick();
        reset = 1'b0;
        check("reset result.v", 32'(result.v), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset btk.n", 32'(btkOut.n), 32'd0);

        // Functional vectors: {mode, condB, condF, A.c, A, B, LUT, expD, expC}
        runOne("asr1", 3'b000, 1'b0, 1'b1, 1'b0, 32'h8000_0001, 32'd1, 8'hCC, 32'hC000_0000, 1'b1);
        runOne("rol4", 3'b011, 1'b0, 1'b0, 1'b1, 32'h8000_0001, 32'd4, 8'hCC, 32'h0000_0018, 1'b1);
        runOne("ror4", 3'b100, 1'b0, 1'b1, 1'b0, 32'h8000_0001, 32'd4, 8'hCC, 32'h1800_0000, 1'b0);
        runOne("lslsat", 3'b010, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'd40, 8'h80, 32'h0000_0000, 1'b1);
        runOne("amt0", 3'b001, 1'b0, 1'b1, 1'b0, 32'h1234_5678, 32'd0, 8'hCC, 32'h1234_5678, 1'b0);
        runOne("lsl31", 3'b010, 1'b0, 1'b1, 1'b0, 32'h0000_0003, 32'd31, 8'hCC, 32'h8000_0000, 1'b1);
        runOne("asr31", 3'b000, 1'b0, 1'b1, 1'b0, 32'h8000_0000, 32'd31, 8'hCC, 32'hFFFF_FFFF, 1'b0);
        runOne("ror31", 3'b100, 1'b0, 1'b0, 1'b0, 32'h0000_0001, 32'd31, 8'h00, 32'h0000_0002, 1'b0);
        runOne("pass", 3'b101, 1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'd5, 8'hFF, 32'hDEAD_BEEF, 1'b0);
        runOne("asrsat", 3'b000, 1'b0, 1'b1, 1'b0, 32'h8000_0000, 32'h100, 8'hF0, 32'hFFFF_FFFF, 1'b1);
        runOne("rolovf", 3'b011, 1'b0, 1'b1, 1'b0, 32'h8000_0001, 32'd40, 8'h10, 32'h0000_0180, 1'b1);

        // Backward-token override while a condB token sits in the last stage.
        btkIn.t = 1'b1; btkIn.v = 1'b0; btkIn.c = 1'b0;
        runOne("condB", 3'b001, 1'b1, 1'b0, 1'b1, 32'h0000_0001, 32'd1, 8'h08, 32'h0000_0000, 1'b1);
        check("condB btk.v", 32'(btkOut.v), 32'd1);
        check("condB btk.c", 32'(btkOut.c), 32'd1);
        check("condB btk.t", 32'(btkOut.t), 32'd1);
        tick();
        check("idle btk.v", 32'(btkOut.v), 32'd0);
        check("idle btk.c", 32'(btkOut.c), 32'd0);
        check("idle busy", 32'(busy), 32'd0);
        btkIn = '0;

        // Six-token stream with a three-cycle downstream stall.
        sent = 0;
        recv = 0;
        sawBackpressure = 1'b0;
        for (int cyc = 0; cyc < 50 && recv < 6; cyc++) begin
            if (sent < 6) drive(3'b010, 1'b0, 1'b0, 1'b0, 32'(sent + 1), 32'(sent));
            else idle();
            btkIn.n = (cyc >= 2 && cyc <= 4);
            #1;
            willAccept = opA.v & ~btkOut.n;
            willDrain  = result.v & ~btkIn.n;
            if (btkOut.n) sawBackpressure = 1'b1;
            if (willDrain) begin
                check($sformatf("stream d%0d", recv), result.d, streamExp[recv]);
                recv++;
            end
            @(posedge clock);
            #1;
            if (willAccept) sent++;
        end
        idle();
        btkIn = '0;
        check("stream recv", 32'(recv), 32'd6);
        check("stream backpressure", 32'(sawBackpressure), 32'd1);
        check("stream tail v", 32'(result.v), 32'd0);
        check("stream tail busy", 32'(busy), 32'd0);

        // Reset with two tokens in flight, then exact post-reset latency.
        drive(3'b101, 1'b0, 1'b0, 1'b0, 32'd5, 32'd0);
        tick();
        drive(3'b101, 1'b0, 1'b0, 1'b0, 32'd6, 32'd0);
        tick();
        check("inflight busy", 32'(busy), 32'd1);
        reset = 1'b1;
        drive(3'b101, 1'b0, 1'b0, 1'b0, 32'd7, 32'd0);
        tick();
        reset = 1'b0;
        idle();
        check("rst2 result.v", 32'(result.v), 32'd0);
        check("rst2 busy", 32'(busy), 32'd0);
        check("rst2 btk.n", 32'(btkOut.n), 32'd0);
        runOne("postrst", 3'b001, 1'b0, 1'b0, 1'b0, 32'h0000_00F0, 32'd4, 8'h00, 32'h0000_000F, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
